goose_physics: RTL and testbench

Per-frame jump physics and hit detection for the goose. It turns the player's jump button into a vertical trajectory sampled once per video frame. It also produces the registered `collision` pulse consumed by `game_controller`, comparing the goose height against that block's `obstacle_pos`. It honours `game_over` (freeze) and `game_reset` (re-arm) from the same controller.

---
 rtl/goose_physics.sv | 109 ++++++++++
 tb/tb_goose_physics.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goose_physics.sv
// Per-frame jump physics for the goose plus the registered obstacle hit flag.
// Height and velocity advance once per frame_tick; game_over freezes, game_reset re-arms.
module goose_physics #(
  parameter int         JUMP_VEL   = 12,
  parameter int         GRAVITY    = 1,
  parameter int         OBSTACLE_H = 16,
  parameter logic [9:0] HIT_LO     = 10'd600,
  parameter logic [9:0] HIT_HI     = 10'd615
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       frame_tick,
  input  logic       jump_button,
  input  logic       game_over,
  input  logic       game_reset,
  input  logic [9:0] obstacle_pos,
  output logic [7:0] goose_height,
  output logic       jumping,
  output logic       collision
);

  typedef enum logic {GROUND, AIR} state_t;

  localparam logic        [7:0] LAUNCH_H = 8'(JUMP_VEL);
  localparam logic signed [7:0] LAUNCH_V = 8'(JUMP_VEL - GRAVITY);
  localparam logic signed [7:0] GRAV_S   = 8'(GRAVITY);
  localparam logic        [8:0] OBS_H    = 9'(OBSTACLE_H);

  state_t            state, state_nx;
  logic signed [7:0] vel, vel_nx;
  logic        [7:0] height_nx;
  logic              jump_pending, pending_nx;
  logic              jump_prev;
  logic              jump_edge;
  logic signed [9:0] next_h;
  logic              in_window;
  logic              hit_nx;

  assign jump_edge = jump_button & ~jump_prev;
  assign in_window = (obstacle_pos >= HIT_LO) && (obstacle_pos <= HIT_HI);
  assign jumping   = (state == AIR);

  // Height is zero-extended, velocity sign-extended, so a descent can go below zero.
  assign next_h = {2'b00, goose_height} + {{2{vel[7]}}, vel};

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_nx   = state;
    height_nx  = goose_height;
    vel_nx     = vel;
    pending_nx = jump_pending;

    if (game_reset) begin
      state_nx   = GROUND;
      height_nx  = 8'd0;
      vel_nx     = 8'sd0;
      pending_nx = 1'b0;
    end else if (game_over) begin
      pending_nx = 1'b0;
    end else begin
      if (state == GROUND && jump_edge) pending_nx = 1'b1;
      if (frame_tick) begin
        unique case (state)
          GROUND: begin
            if (jump_pending | jump_edge) begin
              state_nx   = AIR;
              height_nx  = LAUNCH_H;
              vel_nx     = LAUNCH_V;
              pending_nx = 1'b0;
            end
          end
          AIR: begin
            if (next_h <= 10'sd0) begin
              state_nx  = GROUND;
              height_nx = 8'd0;
              vel_nx    = 8'sd0;
            end else begin
              height_nx = next_h[7:0];
              vel_nx    = vel - GRAV_S;
            end
          end
          default: state_nx = GROUND;
        endcase
      end
    end

    hit_nx = ~game_over & ~game_reset & in_window & ({1'b0, goose_height} < OBS_H);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!sys_rst_n) begin
      state        <= GROUND;
      goose_height <= 8'd0;
      vel          <= 8'sd0;
      jump_pending <= 1'b0;
      jump_prev    <= 1'b0;
      collision    <= 1'b0;
    end else begin
      state        <= state_nx;
      goose_height <= height_nx;
      vel          <= vel_nx;
      jump_pending <= pending_nx;
      jump_prev    <= jump_button;
      collision    <= hit_nx;
    end
  end

endmodule

// File: tb/tb_goose_physics.sv
// Directed bench for goose_physics: jump trajectory, freeze, re-arm priority and hit window.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_goose_physics;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       jump_button = 1'b0;
  logic       game_over = 1'b0;
  logic       game_reset = 1'b0;
  logic [9:0] obstacle_pos = 10'd0;
  logic [7:0] goose_height;
  logic       jumping;
  logic       collision;

  int checks = 0;
  int fails  = 0;

  goose_physics dut (
    .clk          (clk),
    .sys_rst_n    (sys_rst_n),
    .frame_tick   (frame_tick),
    .jump_button  (jump_button),
    .game_over    (game_over),
    .game_reset   (game_reset),
    .obstacle_pos (obstacle_pos),
    .goose_height (goose_height),
    .jumping      (jumping),
    .collision    (collision)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle frame strobe; returns on the falling edge right after the sampling edge.
  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ground_reset();
    game_reset = 1'b1;
    @(negedge clk);
    game_reset  = 1'b0;
    jump_button = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      jump_button  = ~jump_button;
      frame_tick   = ~frame_tick;
      obstacle_pos = 10'd605;
      @(negedge clk);
      checks++;
      if ({goose_height, jumping, collision} !== 10'd0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: height=%0d jumping=%b collision=%b, need 0/0/0",
                 i, goose_height, jumping, collision);
      end
    end
    sys_rst_n    = 1'b1;
    frame_tick   = 1'b0;
    jump_button  = 1'b0;
    obstacle_pos = 10'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({goose_height, jumping, collision} !== 10'd0) begin
        fails++;
        $display("FAIL reset_release[%0d]: height=%0d jumping=%b collision=%b, need 0/0/0",
                 i, goose_height, jumping, collision);
      end
    end
  endtask

  task automatic test_full_jump();
    int exp_h [25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                       77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
    jump_button = 1'b1;
    idle(4);
    checks++;
    if (goose_height !== 8'd0 || jumping !== 1'b0) begin
      fails++;
      $display("FAIL pending_no_tick: height=%0d jumping=%b, need 0/0", goose_height, jumping);
    end
    for (int t = 0; t < 25; t++) begin
      pulse_tick();
      checks++;
      if (goose_height !== 8'(exp_h[t])) begin
        fails++;
        $display("FAIL jump_height[tick %0d]: got %0d, need %0d", t + 1, goose_height, exp_h[t]);
      end
      checks++;
      if (jumping !== (t != 24)) begin
        fails++;
        $display("FAIL jump_flag[tick %0d]: got %b, need %b", t + 1, jumping, (t != 24));
      end
      if (t == 5) begin
        jump_button = 1'b0;
        @(negedge clk);
        jump_button = 1'b1;
      end
      idle(98);
    end
    pulse_tick();
    checks++;
    if (goose_height !== 8'd0 || jumping !== 1'b0) begin
      fails++;
      $display("FAIL midair_edge_dropped: height=%0d jumping=%b, need 0/0", goose_height, jumping);
    end
  endtask

  task automatic test_coincident();
    jump_button = 1'b0;
    @(negedge clk);
    jump_button = 1'b1;
    pulse_tick();
    checks++;
    if (goose_height !== 8'd12 || jumping !== 1'b1) begin
      fails++;
      $display("FAIL coincident_launch: height=%0d jumping=%b, need 12/1", goose_height, jumping);
    end
    ground_reset();
    checks++;
    if (goose_height !== 8'd0 || jumping !== 1'b0) begin
      fails++;
      $display("FAIL game_reset_lands: height=%0d jumping=%b, need 0/0", goose_height, jumping);
    end
  endtask

  task automatic test_collision();
    logic prev_exp = 1'b0;
    logic exp_c;
    for (int p = 598; p <= 618; p++) begin
      obstacle_pos = 10'(p);
      exp_c = (p >= 600) && (p <= 615);
      #1;
      checks++;
      if (collision !== prev_exp) begin
        fails++;
        $display("FAIL hit_latency[pos %0d]: got %b, need %b", p, collision, prev_exp);
      end
      @(negedge clk);
      checks++;
      if (collision !== exp_c) begin
        fails++;
        $display("FAIL hit_ground[pos %0d]: got %b, need %b", p, collision, exp_c);
      end
      prev_exp = exp_c;
    end
    obstacle_pos = 10'd0;
    jump_button  = 1'b1;
    pulse_tick();
    obstacle_pos = 10'd605;
    @(negedge clk);
    checks++;
    if (collision !== 1'b1) begin
      fails++;
      $display("FAIL hit_low_air: got %b at height %0d, need 1", collision, goose_height);
    end
    pulse_tick();
    checks++;
    if (collision !== 1'b1) begin
      fails++;
      $display("FAIL hit_height_latency: got %b, need 1", collision);
    end
    @(negedge clk);
    checks++;
    if (collision !== 1'b0) begin
      fails++;
      $display("FAIL hit_clear_at_23: got %b, need 0", collision);
    end
    pulse_tick();
    pulse_tick();
    for (int p = 598; p <= 618; p++) begin
      obstacle_pos = 10'(p);
      @(negedge clk);
      checks++;
      if (collision !== 1'b0 || goose_height !== 8'd42) begin
        fails++;
        $display("FAIL hit_high[pos %0d]: collision=%b height=%0d, need 0/42",
                 p, collision, goose_height);
      end
    end
    obstacle_pos = 10'd0;
    ground_reset();
  endtask

  task automatic test_freeze();
    jump_button = 1'b1;
    for (int t = 0; t < 5; t++) begin
      pulse_tick();
      idle(2);
    end
    obstacle_pos = 10'd605;
    game_over    = 1'b1;
    for (int t = 0; t < 10; t++) begin
      pulse_tick();
      idle(2);
      checks++;
      if (goose_height !== 8'd50 || jumping !== 1'b1 || collision !== 1'b0) begin
        fails++;
        $display("FAIL freeze[%0d]: height=%0d jumping=%b collision=%b, need 50/1/0",
                 t, goose_height, jumping, collision);
      end
    end
    jump_button = 1'b0;
    @(negedge clk);
    jump_button = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    @(negedge clk);
    pulse_tick();
    checks++;
    if (goose_height !== 8'd57) begin
      fails++;
      $display("FAIL freeze_resume: height=%0d, need 57", goose_height);
    end
    ground_reset();
    idle(1);
    checks++;
    if (collision !== 1'b1) begin
      fails++;
      $display("FAIL hit_before_over: got %b, need 1", collision);
    end
    game_over = 1'b1;
    @(negedge clk);
    checks++;
    if (collision !== 1'b0) begin
      fails++;
      $display("FAIL hit_drop_on_over: got %b, need 0", collision);
    end
    jump_button = 1'b1;
    idle(2);
    game_over = 1'b0;
    @(negedge clk);
    pulse_tick();
    checks++;
    if (goose_height !== 8'd0 || jumping !== 1'b0) begin
      fails++;
      $display("FAIL over_edge_dropped: height=%0d jumping=%b, need 0/0", goose_height, jumping);
    end
    obstacle_pos = 10'd0;
    jump_button  = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    jump_button = 1'b1;
    pulse_tick();
    pulse_tick();
    pulse_tick();
    jump_button = 1'b0;
    @(negedge clk);
    checks++;
    if (goose_height !== 8'd33) begin
      fails++;
      $display("FAIL priority_setup: height=%0d, need 33", goose_height);
    end
    game_reset  = 1'b1;
    frame_tick  = 1'b1;
    jump_button = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
    frame_tick = 1'b0;
    checks++;
    if (goose_height !== 8'd0 || jumping !== 1'b0) begin
      fails++;
      $display("FAIL priority_reset: height=%0d jumping=%b, need 0/0", goose_height, jumping);
    end
    for (int t = 0; t < 3; t++) begin
      idle(2);
      pulse_tick();
      checks++;
      if (goose_height !== 8'd0 || jumping !== 1'b0) begin
        fails++;
        $display("FAIL priority_no_launch[%0d]: height=%0d jumping=%b, need 0/0",
                 t, goose_height, jumping);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_jump();
    test_coincident();
    test_collision();
    test_freeze();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
